usr_shift_ctrl: RTL

USR_SHIFT_CTRL -- requirements
Module: usr_shift_ctrl

---
 rtl/usr_shift_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/usr_shift_ctrl.sv
// Command-driven sequencer for an external 4-bit universal shift register.
// It accepts load, shift and readback commands and reports the register contents when each one finishes.
module usr_shift_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_amt,
    input  logic [3:0] cmd_data,
    output logic [1:0] usr_cnt,
    output logic [3:0] usr_in,
    input  logic [3:0] usr_q,
    output logic       done,
    output logic [3:0] result,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        CAPTURE
    } state_t;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_SHL  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [1:0] op_q;
    logic [3:0] data_q;
    logic       accept;

    assign accept = cmd_valid & cmd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Command latch, shift down-counter and the captured result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= 3'd0;
            op_q   <= OP_NOP;
            data_q <= 4'd0;
            result <= 4'd0;
            done   <= 1'b0;
        end else begin
            done <= (state == CAPTURE);
            if (accept) begin
                cnt    <= cmd_amt;
                op_q   <= cmd_op;
                data_q <= cmd_data;
            end else if (state == SHIFT) begin
                cnt <= cnt - 3'd1;
            end
            if (state == CAPTURE) begin
                result <= usr_q;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD) begin
                        state_nxt = LOAD;
                    end else if ((cmd_op != OP_NOP) && (cmd_amt != 3'd0)) begin
                        state_nxt = SHIFT;
                    end else begin
                        state_nxt = CAPTURE;
                    end
                end
            end
            LOAD: begin
                state_nxt = CAPTURE;
            end
            // Exit on the last shift cycle; the guard also covers a zero count
            SHIFT: begin
                if (cnt <= 3'd1) begin
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        busy      = (state != IDLE);
        usr_cnt   = MODE_HOLD;
        usr_in    = 4'd0;
        case (state)
            LOAD: begin
                usr_cnt = MODE_LOAD;
                usr_in  = data_q;
            end
            SHIFT: begin
                usr_cnt = (op_q == OP_SHL) ? MODE_SHL : MODE_SHR;
            end
            default: begin
                usr_cnt = MODE_HOLD;
            end
        endcase
    end

endmodule
